// File: rtl/ex_div_unit.sv
// EX-stage iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the front end via o_busy and returns one registered result per op.
module ex_div_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_sel_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] a_raw_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            dz_q;
  logic            ovf_q;

  function automatic logic [XLEN-1:0] spec_res(
    input logic            is_rem,
    input logic            dz,
    input logic [XLEN-1:0] a
  );
    if (dz) return is_rem ? a : '1;
    return is_rem ? '0 : a;
  endfunction

  logic            start_ok;
  logic            in_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            in_dz;
  logic            in_ovf;
  logic [XLEN-1:0] in_res;

  assign start_ok = i_start & i_funct3[2];
  assign in_sgn   = ~i_funct3[0];
  assign a_neg    = in_sgn & i_rs1_data[XLEN-1];
  assign b_neg    = in_sgn & i_rs2_data[XLEN-1];
  assign a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
  assign b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
  assign in_dz    = (i_rs2_data == '0);
  assign in_ovf   = in_sgn
                  & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                  & (i_rs2_data == '1);
  assign in_res   = spec_res(i_funct3[1], in_dz, i_rs1_data);

  // Stored remainder is always < divisor, so only the shifted value needs XLEN+1 bits.
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] fin_q;
  logic [XLEN-1:0] fin_r;
  logic [XLEN-1:0] fin;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, dvsr_q};
  assign rem_nx = ge ? (rem_sh[XLEN-1:0] - dvsr_q) : rem_sh[XLEN-1:0];
  assign quo_nx = {quo_q[XLEN-2:0], ge};
  assign fin_q  = neg_q_q ? -quo_nx : quo_nx;
  assign fin_r  = neg_r_q ? -rem_nx : rem_nx;
  assign fin    = (dz_q | ovf_q) ? spec_res(rem_sel_q, dz_q, a_raw_q)
                : (rem_sel_q ? fin_r : fin_q);

  assign o_busy = ((state_q == IDLE) & start_ok & ~i_flush)
                | (state_q == CALC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      rd_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      a_raw_q   <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      o_done    <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      o_done  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          o_done <= 1'b0;
          if (start_ok) begin
            rem_sel_q <= i_funct3[1];
            rd_q      <= i_rd_addr;
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvsr_q    <= b_mag;
            a_raw_q   <= i_rs1_data;
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            dz_q      <= in_dz;
            ovf_q     <= in_ovf;
            if (EARLY_OUT && (in_dz || in_ovf)) begin
              state_q   <= DONE;
              o_done    <= 1'b1;
              o_result  <= in_res;
              o_rd_addr <= i_rd_addr;
            end else begin
              state_q <= CALC;
              cnt_q   <= CW'(XLEN - 1);
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q   <= DONE;
            o_done    <= 1'b1;
            o_result  <= fin;
            o_rd_addr <= rd_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          o_done  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: arithmetic, special cases,
// latency, flush, ignored restart and async reset.
module tb_ex_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  ex_div_unit dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_start    (i_start),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Waits for o_done starting in cycle n0; returns done cycle and busy cycles seen.
  task automatic wait_done(input int n0, output int n, output int busy);
    n = n0;
    busy = 0;
    while (o_done !== 1'b1 && n < 100) begin
      if (o_busy === 1'b1) busy++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int lat);
    int n;
    int busy;
    i_funct3   = fn;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    i_start    = 1'b1;
    #1;
    check({tag, "_busy0"}, 32'(o_busy), 32'd1);
    tick();
    i_start = 1'b0;
    wait_done(1, n, busy);
    check({tag, "_lat"}, n, lat);
    check({tag, "_busycyc"}, busy + 1, lat);
    check({tag, "_res"}, o_result, exp);
    check({tag, "_rd"}, 32'(o_rd_addr), 32'(rd));
    check({tag, "_busydone"}, 32'(o_busy), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int n;
    int busy;
    int seen;
    i_rst_n    = 1'b0;
    i_flush    = 1'b0;
    i_start    = 1'b0;
    i_funct3   = '0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_rd_addr  = '0;
    tick();
    tick();
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_res", o_result, 32'd0);
    check("rst_rd", 32'(o_rd_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    #2 i_rst_n = 1'b1;
    tick();

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    run_op("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2", F_REM, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33);
    run_op("remu_big_2", F_REMU, 32'hFFFFFFF9, 32'd2, 5'd8, 32'd1, 33);
    run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33);
    run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFFFFFE, 5'd11, 32'd1, 33);
    run_op("divu_min_m1", F_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd12,
           32'd0, 33);
    run_op("div_5_0", F_DIV, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
    run_op("rem_5_0", F_REM, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run_op("divu_7_0", F_DIVU, 32'd7, 32'd0, 5'd15, 32'hFFFFFFFF, 1);
    run_op("rem_ovf", F_REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 1);
    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd17,
           32'h80000000, 1);

    // flush together with start in IDLE: not accepted
    i_funct3   = F_DIVU;
    i_rs1_data = 32'd50;
    i_rs2_data = 32'd5;
    i_rd_addr  = 5'd20;
    i_start    = 1'b1;
    i_flush    = 1'b1;
    #1;
    check("idleflush_busy", 32'(o_busy), 32'd0);
    tick();
    i_start = 1'b0;
    i_flush = 1'b0;
    #1;
    check("idleflush_busy2", 32'(o_busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done === 1'b1) seen++;
      tick();
    end
    check("idleflush_nodone", seen, 0);

    // flush at CALC cycle 10
    i_funct3   = F_DIVU;
    i_rs1_data = 32'd1000;
    i_rs2_data = 32'd3;
    i_rd_addr  = 5'd9;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    i_flush = 1'b1;
    #1;
    check("flush_busy_calc", 32'(o_busy), 32'd1);
    tick();
    i_flush = 1'b0;
    check("flush_busy_idle", 32'(o_busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done === 1'b1) seen++;
      tick();
    end
    check("flush_nodone", seen, 0);
    check("flush_hold_res", o_result, 32'h80000000);
    check("flush_hold_rd", 32'(o_rd_addr), 32'd17);
    run_op("after_flush", F_DIVU, 32'd1000, 32'd3, 5'd9, 32'd333, 33);

    // restart pulse during CALC is ignored
    i_funct3   = F_DIV;
    i_rs1_data = 32'd100;
    i_rs2_data = 32'hFFFFFFF9;
    i_rd_addr  = 5'd3;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    i_funct3   = F_DIVU;
    i_rs1_data = 32'd9;
    i_rs2_data = 32'd3;
    i_rd_addr  = 5'd4;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(6, n, busy);
    check("restart_lat", n, 33);
    check("restart_res", o_result, 32'hFFFFFFF2);
    check("restart_rd", 32'(o_rd_addr), 32'd3);
    tick();
    tick();
    check("restart_busy", 32'(o_busy), 32'd0);

    // async reset mid-CALC
    i_funct3   = F_DIVU;
    i_rs1_data = 32'd77;
    i_rs2_data = 32'd4;
    i_rd_addr  = 5'd21;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_res", o_result, 32'd0);
    check("arst_rd", 32'(o_rd_addr), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    tick();
    #2 i_rst_n = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done === 1'b1) seen++;
      tick();
    end
    check("arst_nodone", seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
